// File: rtl/pipe_dmem_responder_pkg.sv
// Shared definitions for the pipeline memory responders.
//   WORD_W     : data word width in bits
//   state_t    : responder FSM encoding (S_IDLE, S_WAIT, S_RESP)
//   addr_legal : 1 when a byte address is word aligned and lies inside
//                a 2^aw-word array
package pipe_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic addr_legal(input logic [WORD_W-1:0] addr,
                                        input int unsigned       aw);
        logic [WORD_W-1:0] hi;
        hi = addr >> (aw + 2);
        return (addr[1:0] == 2'b00) && (hi == '0);
    endfunction

endpackage

// File: rtl/pipe_dmem_responder_if.sv
// MEM-stage load/store bus between the CPU and the data-memory responder.
//   req, we, addr, wdata : request side, driven by the CPU (master)
//   rdata, ready, err    : completion side, driven by the responder (slave)
//   busy                 : stall level, driven by the responder
interface pipe_dmem_responder_if;
    import pipe_mem_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, busy, err
    );

endinterface

// File: rtl/pipe_dmem_responder_array.sv
// Single-port word array with synchronous write and registered read.
//   clk   : rising-edge clock
//   en    : access enable
//   we    : 1 = write wdata, 0 = read into rdata
//   waddr : word address (shared by read and write)
//   wdata : write data
//   rdata : registered read data, unchanged by writes and idle cycles
// No reset so the array maps onto block RAM.
module pipe_dmem_array
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[waddr] <= wdata;
            end else begin
                rdata <= mem[waddr];
            end
        end
    end

endmodule

// File: rtl/pipe_dmem_responder.sv
// Data-memory responder with a configurable number of wait states.
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset
//   bus  : slave side of the MEM-stage load/store bus
//          (req/we/addr/wdata in; rdata/ready/busy/err out)
// A request is latched in IDLE, held for WAIT_CYCLES+1 cycles in WAIT,
// performed on the WAIT->RESP edge and acknowledged by ready in RESP.
module pipe_dmem_responder
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  clrn,
    pipe_dmem_responder_if.slave  bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic              ready_q;
    logic              err_q;
    logic              zero_q;

    logic              we_q;
    logic              bad_q;
    logic [ADDR_W-1:0] widx_q;
    logic [WORD_W-1:0] wdata_q;

    logic              access;
    logic [WORD_W-1:0] arr_rdata;

    // The array is touched only in the last WAIT cycle of a legal access,
    // so an aborting reset (which forces IDLE at once) also blocks the write.
    assign access = (state == S_WAIT) && (cnt == 4'd0) && !bad_q;

    pipe_dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (access),
        .we    (we_q),
        .waddr (widx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign bus.busy  = (state != S_IDLE);
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    // The array output register has no reset; zero_q masks it after reset
    // and after an illegal access so rdata reads as 0 until the next load.
    assign bus.rdata = zero_q ? '0 : arr_rdata;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (bus.req) begin
                        cnt   <= WAIT_INIT;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= S_RESP;
                        ready_q <= 1'b1;
                        err_q   <= bad_q;
                        if (bad_q) begin
                            zero_q <= 1'b1;
                        end else if (!we_q) begin
                            zero_q <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Request capture; only IDLE looks at the bus, later changes are ignored.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && bus.req) begin
            we_q    <= bus.we;
            bad_q   <= !addr_legal(bus.addr, ADDR_W);
            widx_q  <= bus.addr[ADDR_W+1:2];
            wdata_q <= bus.wdata;
        end
    end

endmodule

// File: tb/tb_pipe_dmem_responder.sv
// Scoreboard bench for pipe_dmem_responder: one instance with two wait
// states and one with none. Drivers push expected completions into queues;
// monitors pop and compare on every ready pulse.
module tb_pipe_dmem_responder;

    logic clk;
    logic clrn;

    pipe_dmem_responder_if bus2();
    pipe_dmem_responder_if bus0();

    pipe_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus2.slave)
    );

    pipe_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus0.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q2_rd[$];
    logic        q2_err[$];
    logic [31:0] q0_rd[$];
    logic        q0_err[$];

    int cyc      = 0;
    bit b2b      = 1'b0;
    int last_rdy = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor, two wait states: ready must follow 4 busy cycles
    int run2      = 0;
    bit prev_rdy2 = 1'b0;
    always @(negedge clk) begin
        if (!clrn) begin
            run2      = 0;
            prev_rdy2 = 1'b0;
        end else begin
            if (prev_rdy2) check("w2_busy_after_ready", {31'd0, bus2.busy}, 32'd0);
            if (bus2.busy === 1'b1) run2++; else run2 = 0;
            if (bus2.ready === 1'b1) begin
                check("w2_busy_cycles", run2, 32'd4);
                if (q2_rd.size() == 0) begin
                    check("w2_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    check("w2_rdata", bus2.rdata, q2_rd.pop_front());
                    check("w2_err", {31'd0, bus2.err}, {31'd0, q2_err.pop_front()});
                end
                if (b2b && last_rdy >= 0) check("w2_ready_period", cyc - last_rdy, 32'd5);
                last_rdy = cyc;
            end
            prev_rdy2 = (bus2.ready === 1'b1);
        end
    end

    // Monitor, zero wait states: ready must follow 2 busy cycles
    int run0      = 0;
    bit prev_rdy0 = 1'b0;
    always @(negedge clk) begin
        if (!clrn) begin
            run0      = 0;
            prev_rdy0 = 1'b0;
        end else begin
            if (prev_rdy0) check("w0_busy_after_ready", {31'd0, bus0.busy}, 32'd0);
            if (bus0.busy === 1'b1) run0++; else run0 = 0;
            if (bus0.ready === 1'b1) begin
                check("w0_busy_cycles", run0, 32'd2);
                if (q0_rd.size() == 0) begin
                    check("w0_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    check("w0_rdata", bus0.rdata, q0_rd.pop_front());
                    check("w0_err", {31'd0, bus0.err}, {31'd0, q0_err.pop_front()});
                end
            end
            prev_rdy0 = (bus0.ready === 1'b1);
        end
    end

    // keep: called at the RESP negedge of the previous access with req still high
    // hold: leave req high after ready for a back-to-back follow-up
    // garble: corrupt wdata once the access is in WAIT
    task automatic acc2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eerr,
                        input bit keep, input bit hold, input bit garble);
        int n;
        if (!keep) @(negedge clk);
        bus2.req   = 1'b1;
        bus2.we    = w;
        bus2.addr  = a;
        bus2.wdata = d;
        q2_rd.push_back(erd);
        q2_err.push_back(eerr);
        if (garble) begin
            repeat (2) @(negedge clk);
            bus2.wdata = ~d;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus2.ready !== 1'b1 && n < 40);
        if (n >= 40) check("w2_ready_timeout", 32'd0, 32'd1);
        if (!hold) bus2.req = 1'b0;
    endtask

    task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eerr);
        int n;
        @(negedge clk);
        bus0.req   = 1'b1;
        bus0.we    = w;
        bus0.addr  = a;
        bus0.wdata = d;
        q0_rd.push_back(erd);
        q0_err.push_back(eerr);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus0.ready !== 1'b1 && n < 40);
        if (n >= 40) check("w0_ready_timeout", 32'd0, 32'd1);
        bus0.req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0;
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_w2_rdata", bus2.rdata, 32'd0);
        check("rst_w2_ready", {31'd0, bus2.ready}, 32'd0);
        check("rst_w2_busy",  {31'd0, bus2.busy},  32'd0);
        check("rst_w2_err",   {31'd0, bus2.err},   32'd0);
        check("rst_w0_rdata", bus0.rdata, 32'd0);
        check("rst_w0_ready", {31'd0, bus0.ready}, 32'd0);
        check("rst_w0_busy",  {31'd0, bus0.busy},  32'd0);
        check("rst_w0_err",   {31'd0, bus0.err},   32'd0);
        clrn = 1'b1;

        // Known old value at 0x10, then a store aborted by reset in WAIT
        acc2(1'b1, 32'h10, 32'h1111_1111, 32'h0, 1'b0, 0, 0, 0);
        @(negedge clk);
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h10; bus2.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mid_w2_busy_before_rst", {31'd0, bus2.busy}, 32'd1);
        clrn = 1'b0;
        #1;
        check("mid_rst_busy",  {31'd0, bus2.busy},  32'd0);
        check("mid_rst_ready", {31'd0, bus2.ready}, 32'd0);
        check("mid_rst_rdata", bus2.rdata, 32'd0);
        bus2.req = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        acc2(1'b0, 32'h10, 32'h0, 32'h1111_1111, 1'b0, 0, 0, 0);

        // Basic store / load
        acc2(1'b1, 32'h40, 32'h1234_5678, 32'h1111_1111, 1'b0, 0, 0, 0);
        acc2(1'b0, 32'h40, 32'h0,         32'h1234_5678, 1'b0, 0, 0, 0);

        // Misaligned store, then confirm word untouched; out-of-range load
        acc2(1'b1, 32'h42,   32'hAAAA_AAAA, 32'h0,         1'b1, 0, 0, 0);
        acc2(1'b0, 32'h40,   32'h0,         32'h1234_5678, 1'b0, 0, 0, 0);
        acc2(1'b0, 32'h1000, 32'h0,         32'h0,         1'b1, 0, 0, 0);

        // Back-to-back with req held; wdata disturbed in WAIT of the second store
        b2b = 1'b1;
        last_rdy = -1;
        acc2(1'b1, 32'h80, 32'hCAFE_F00D, 32'h0,         1'b0, 0, 1, 0);
        acc2(1'b1, 32'h80, 32'h0BAD_C0DE, 32'h0,         1'b0, 1, 1, 1);
        acc2(1'b0, 32'h80, 32'h0,         32'h0BAD_C0DE, 1'b0, 1, 0, 0);
        @(negedge clk);
        b2b = 1'b0;

        // Zero wait states
        acc0(1'b1, 32'h20, 32'h5A5A_5A5A, 32'h0,         1'b0);
        acc0(1'b0, 32'h20, 32'h0,         32'h5A5A_5A5A, 1'b0);

        repeat (4) @(negedge clk);
        check("w2_queue_drained", q2_rd.size(), 32'd0);
        check("w0_queue_drained", q0_rd.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
